// File: rtl/cmp_share_arbiter_if.sv
// rtl/cmp_share_arbiter_if.sv - requester and comparator bus of the shared comparator arbiter
interface cmp_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         cmp_a;
  logic [WIDTH-1:0]         cmp_b;
  logic                     cmp_gt;
  logic                     cmp_eq;
  logic                     cmp_lt;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic                     rsp_gt;
  logic                     rsp_eq;
  logic                     rsp_lt;
  logic                     busy;
  logic                     err_onehot;
  logic [15:0]              op_count;

  // Environment side: requesters plus the comparator flags
  modport master (
    output req, req_a, req_b, cmp_gt, cmp_eq, cmp_lt,
    input  gnt, cmp_a, cmp_b, rsp_valid, rsp_gt, rsp_eq, rsp_lt, busy, err_onehot, op_count
  );

  // Arbiter side
  modport slave (
    input  req, req_a, req_b, cmp_gt, cmp_eq, cmp_lt,
    output gnt, cmp_a, cmp_b, rsp_valid, rsp_gt, rsp_eq, rsp_lt, busy, err_onehot, op_count
  );
endinterface

// File: rtl/cmp_share_arbiter.sv
// rtl/cmp_share_arbiter.sv - round-robin sharing of one magnitude comparator between requesters
module cmp_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  cmp_share_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id;
  logic [IDW-1:0] win_id;
  logic           win_found;
  logic           flags_onehot;

  // Round-robin search: first set req bit starting at ptr, wrapping modulo NUM_REQ
  always_comb begin : winner_search
    int j;
    j         = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_found && bus.req[j]) begin
        win_found = 1'b1;
        win_id    = IDW'(j);
      end
    end
  end

  assign flags_onehot = ({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt} == 3'b100) ||
                        ({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt} == 3'b010) ||
                        ({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt} == 3'b001);

  assign bus.busy = (state != S_IDLE);

  // Grant / capture / respond sequencer; reset drops any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ptr            <= '0;
      id             <= '0;
      bus.gnt        <= '0;
      bus.rsp_valid  <= '0;
      bus.cmp_a      <= '0;
      bus.cmp_b      <= '0;
      bus.rsp_gt     <= 1'b0;
      bus.rsp_eq     <= 1'b0;
      bus.rsp_lt     <= 1'b0;
      bus.err_onehot <= 1'b0;
      bus.op_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            bus.cmp_a <= bus.req_a[win_id*WIDTH +: WIDTH];
            bus.cmp_b <= bus.req_b[win_id*WIDTH +: WIDTH];
            bus.gnt   <= NUM_REQ'(1) << win_id;
            id        <= win_id;
            state     <= S_EVAL;
          end
        end
        S_EVAL: begin
          bus.rsp_gt    <= bus.cmp_gt;
          bus.rsp_eq    <= bus.cmp_eq;
          bus.rsp_lt    <= bus.cmp_lt;
          bus.rsp_valid <= NUM_REQ'(1) << id;
          bus.gnt       <= '0;
          if (!flags_onehot) bus.err_onehot <= 1'b1;
          state         <= S_RESP;
        end
        S_RESP: begin
          bus.rsp_valid <= '0;
          ptr           <= (id == IDW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
          if (bus.op_count != 16'hFFFF) bus.op_count <= bus.op_count + 16'd1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb/tb_cmp_share_arbiter.sv - directed self-checking bench for cmp_share_arbiter
module tb_cmp_share_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic force_bad;
  int   checks = 0;
  int   errors = 0;

  cmp_share_arbiter_if #(.NUM_REQ(4), .WIDTH(4)) bus ();

  cmp_share_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural comparator; force_bad makes gt and lt both assert
  assign bus.cmp_gt = force_bad ? 1'b1 : (bus.cmp_a > bus.cmp_b);
  assign bus.cmp_eq = force_bad ? 1'b0 : (bus.cmp_a == bus.cmp_b);
  assign bus.cmp_lt = force_bad ? 1'b1 : (bus.cmp_a < bus.cmp_b);

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] g, output logic [3:0] rv, output logic [2:0] fl);
    bus.req_a[idx*4 +: 4] = a;
    bus.req_b[idx*4 +: 4] = b;
    bus.req[idx] = 1'b1;
    tick();
    g = bus.gnt;
    bus.req[idx] = 1'b0;
    tick();
    rv = bus.rsp_valid;
    fl = {bus.rsp_gt, bus.rsp_eq, bus.rsp_lt};
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b1111;
    tick();
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); end
    checks++; if ({bus.cmp_a, bus.cmp_b} !== 8'h00) begin errors++; $display("FAIL reset_cmp_ab: got %h want 00", {bus.cmp_a, bus.cmp_b}); end
    checks++; if ({bus.rsp_gt, bus.rsp_eq, bus.rsp_lt} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}); end
    checks++; if ({bus.busy, bus.err_onehot} !== 2'b00) begin errors++; $display("FAIL reset_busy_err: got %b want 00", {bus.busy, bus.err_onehot}); end
    checks++; if (bus.op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count: got %0d want 0", bus.op_count); end
    bus.req = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.req_a[3:0] = 4'hB;
    bus.req_b[3:0] = 4'h9;
    bus.req = 4'b0001;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", bus.gnt); end
    checks++; if ({bus.cmp_a, bus.cmp_b} !== 8'hB9) begin errors++; $display("FAIL single_cmp_ab: got %h want b9", {bus.cmp_a, bus.cmp_b}); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_eval: got %b want 1", bus.busy); end
    bus.req = 4'b0000;
    tick();
    checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b want 0001", bus.rsp_valid); end
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_drop: got %b want 0000", bus.gnt); end
    checks++; if ({bus.rsp_gt, bus.rsp_eq, bus.rsp_lt} !== 3'b100) begin errors++; $display("FAIL single_flags: got %b want 100", {bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}); end
    tick();
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_pulse: got %b want 0000", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b want 0", bus.busy); end
    checks++; if (bus.op_count !== 16'd1) begin errors++; $display("FAIL single_op_count: got %0d want 1", bus.op_count); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    do_reset();
    bus.req_a = {4{4'h5}};
    bus.req_b = {4{4'h5}};
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++; if (bus.gnt !== exp_seq[n]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", n, bus.gnt, exp_seq[n]); end
      tick();
      checks++; if (bus.rsp_valid !== exp_seq[n] || bus.rsp_eq !== 1'b1) begin errors++; $display("FAIL rr_rsp[%0d]: got %b eq=%b want %b eq=1", n, bus.rsp_valid, bus.rsp_eq, exp_seq[n]); end
      tick();
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rr_gap[%0d]: got %b want 0000", n, bus.gnt); end
    end
    bus.req = 4'b0000;
    checks++; if (bus.op_count !== 16'd5) begin errors++; $display("FAIL rr_op_count: got %0d want 5", bus.op_count); end
  endtask

  task automatic test_ptr_rotation();
    logic [3:0] g, rv;
    logic [2:0] fl;
    do_reset();
    run_op(1, 4'h3, 4'h3, g, rv, fl);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL ptr_first_gnt: got %b want 0010", g); end
    bus.req = 4'b0101;
    tick();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL ptr_req2_first: got %b want 0100", bus.gnt); end
    bus.req = 4'b0001;
    tick();
    checks++; if (bus.rsp_valid !== 4'b0100) begin errors++; $display("FAIL ptr_rsp2: got %b want 0100", bus.rsp_valid); end
    tick();
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL ptr_req0_second: got %b want 0001", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL ptr_rsp0: got %b want 0001", bus.rsp_valid); end
    tick();
  endtask

  task automatic test_flags();
    logic [3:0] g, rv;
    logic [2:0] fl;
    do_reset();
    run_op(0, 4'h7, 4'h7, g, rv, fl);
    checks++; if (fl !== 3'b010 || rv !== 4'b0001) begin errors++; $display("FAIL flags_eq: got %b rv=%b want 010 rv=0001", fl, rv); end
    run_op(1, 4'h0, 4'hF, g, rv, fl);
    checks++; if (fl !== 3'b001 || rv !== 4'b0010) begin errors++; $display("FAIL flags_lt: got %b rv=%b want 001 rv=0010", fl, rv); end
    run_op(2, 4'hF, 4'h0, g, rv, fl);
    checks++; if (fl !== 3'b100 || rv !== 4'b0100) begin errors++; $display("FAIL flags_gt: got %b rv=%b want 100 rv=0100", fl, rv); end
    checks++; if ({bus.cmp_a, bus.cmp_b} !== 8'hF0) begin errors++; $display("FAIL flags_cmp_hold: got %h want f0", {bus.cmp_a, bus.cmp_b}); end
    checks++; if (bus.op_count !== 16'd3) begin errors++; $display("FAIL flags_op_count: got %0d want 3", bus.op_count); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    bus.req_a[3:0] = 4'h3;
    bus.req_b[3:0] = 4'h4;
    bus.req = 4'b0001;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL mid_gnt: got %b want 0001", bus.gnt); end
    rst = 1'b1;
    bus.req = 4'b0000;
    tick();
    rst = 1'b0;
    checks++; if ({bus.gnt, bus.rsp_valid} !== 8'h00) begin errors++; $display("FAIL mid_pulses: got %h want 00", {bus.gnt, bus.rsp_valid}); end
    checks++; if ({bus.cmp_a, bus.cmp_b} !== 8'h00 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_cmp_busy: got %h busy=%b want 00 busy=0", {bus.cmp_a, bus.cmp_b}, bus.busy); end
    tick();
    checks++; if (bus.rsp_valid !== 4'b0000 || bus.op_count !== 16'd0) begin errors++; $display("FAIL mid_no_rsp: got %b cnt=%0d want 0000 cnt=0", bus.rsp_valid, bus.op_count); end
    bus.req = 4'b1010;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL mid_ptr_zero: got %b want 0010", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_err_sticky();
    logic [3:0] g, rv;
    logic [2:0] fl;
    do_reset();
    force_bad = 1'b1;
    run_op(0, 4'h2, 4'h2, g, rv, fl);
    force_bad = 1'b0;
    checks++; if (bus.err_onehot !== 1'b1 || fl !== 3'b101) begin errors++; $display("FAIL err_set: got %b fl=%b want 1 fl=101", bus.err_onehot, fl); end
    run_op(1, 4'h9, 4'h1, g, rv, fl);
    checks++; if (bus.err_onehot !== 1'b1 || fl !== 3'b100) begin errors++; $display("FAIL err_sticky: got %b fl=%b want 1 fl=100", bus.err_onehot, fl); end
    do_reset();
    checks++; if (bus.err_onehot !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", bus.err_onehot); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.req_a[15:12] = 4'h1;
    bus.req_b[15:12] = 4'h8;
    bus.req = 4'b1000;
    tick();
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL b2b_gnt1: got %b want 1000", bus.gnt); end
    tick();
    checks++; if (bus.rsp_valid !== 4'b1000 || bus.rsp_lt !== 1'b1) begin errors++; $display("FAIL b2b_rsp1: got %b lt=%b want 1000 lt=1", bus.rsp_valid, bus.rsp_lt); end
    tick();
    checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b busy=%b want 0000 busy=0", bus.gnt, bus.busy); end
    tick();
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL b2b_gnt2: got %b want 1000", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    tick();
    checks++; if (bus.op_count !== 16'd2) begin errors++; $display("FAIL b2b_op_count: got %0d want 2", bus.op_count); end
  endtask

  initial begin
    rst = 1'b1;
    force_bad = 1'b0;
    bus.req = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_rotation();
    test_flags();
    test_reset_mid_op();
    test_err_sticky();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
